// File: rtl/mem_arbiter.sv
// Two-port memory arbiter that puts an instruction-fetch port and a data port
// in front of one single-ported 32-bit word memory, using round-robin grant.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int DEPTH = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_wenable,
    input  logic [31:0] m_rdata
);

    localparam logic [31:0] LIMIT = 32'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_IF,
        SERVE_D,
        ACK
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_d;
    logic        ack_d;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_we;
    logic        any_req;
    logic        grant_d;
    logic        oor;
    logic        serving;

    assign any_req = if_req | d_req;
    assign grant_d = d_req & (~if_req | ~last_d);
    assign oor     = (cmd_addr >= LIMIT);
    assign serving = (state == SERVE_IF) | (state == SERVE_D);

    // State register; reset aborts any in-flight access immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: grant from IDLE, one serve cycle, one ack cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (any_req) state_nxt = grant_d ? SERVE_D : SERVE_IF;
            end
            SERVE_IF: state_nxt = ACK;
            SERVE_D:  state_nxt = ACK;
            ACK:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs: memory bus driven only while serving, acks only in ACK
    always_comb begin
        m_addr    = 32'h0;
        m_wdata   = 32'h0;
        m_wenable = 1'b0;
        if_ack    = 1'b0;
        d_ack     = 1'b0;
        if (serving) begin
            m_addr  = cmd_addr;
            m_wdata = cmd_wdata;
        end
        if (state == SERVE_D) m_wenable = cmd_we & ~oor;
        if (state == ACK) begin
            if_ack = ~ack_d;
            d_ack  = ack_d;
        end
    end

    // Command latch, round-robin history, read-data and error capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d    <= 1'b0;
            ack_d     <= 1'b0;
            cmd_addr  <= 32'h0;
            cmd_wdata <= 32'h0;
            cmd_we    <= 1'b0;
            if_rdata  <= 32'h0;
            d_rdata   <= 32'h0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (state == IDLE && any_req) begin
                last_d    <= grant_d;
                cmd_addr  <= grant_d ? d_addr : if_addr;
                cmd_wdata <= grant_d ? d_wdata : 32'h0;
                cmd_we    <= grant_d & d_we;
            end
            if (serving) begin
                err   <= oor;
                ack_d <= (state == SERVE_D);
            end
            if (state == SERVE_IF) begin
                if_rdata <= oor ? 32'h0 : m_rdata;
            end
            if (state == SERVE_D && !cmd_we) begin
                d_rdata <= oor ? 32'h0 : m_rdata;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DEPTH, 128, number of 32-bit words in the attached memory; word addressing.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset rst, asynchronous, active-high.
REQ-004 if_req  input  1  instruction-fetch read request; held with if_addr until if_ack.
REQ-005 if_addr  input  32  fetch word address.
REQ-006 if_ack  output  1  one-cycle pulse; fetch complete, if_rdata valid.
REQ-007 if_rdata  output  32  registered fetch data.
REQ-008 d_req  input  1  data-port request; held with d_we, d_addr and d_wdata until d_ack.
REQ-009 d_we  input  1  1 = write, 0 = read.
REQ-010 d_addr  input  32  data word address.
REQ-011 d_wdata  input  32  write data.
REQ-012 d_ack  output  1  one-cycle pulse; data access complete, d_rdata valid for reads.
REQ-013 d_rdata  output  32  registered read data.
REQ-014 err  output  1  pulses together with if_ack or d_ack when the address is >= DEPTH.
REQ-015 m_addr  output  32  memory address.
REQ-016 m_wdata  output  32  memory write data.
REQ-017 m_wenable  output  1  memory write enable; the memory writes on the clk edge.
REQ-018 m_rdata  input  32  memory read data; combinational from m_addr.

Function
REQ-019 FSM states: IDLE, SERVE_IF, SERVE_D, ACK.
REQ-020 IDLE: on the edge where any request is high, latch the granted port's addr/we/wdata into a command register and go to SERVE_IF or SERVE_D.
REQ-021 IDLE with no request: remain in IDLE.
REQ-022 Arbitration: lone requester wins; if both request, grant the port not granted last (round-robin); last_grant resets to IF, so D wins the first conflict.
REQ-023 last_grant updates only on the IDLE->SERVE transition.
REQ-024 SERVE_x: m_addr = latched addr, m_wdata = latched wdata; m_wenable = 1 only in SERVE_D with we=1 and addr < DEPTH.
REQ-025 SERVE_x -> ACK on the next edge, unconditionally.
REQ-026 On the SERVE_x -> ACK edge, capture m_rdata into x_rdata (0 if addr >= DEPTH).
REQ-027 On the SERVE_x -> ACK edge, set err = (addr >= DEPTH).
REQ-028 Out of range (addr >= DEPTH): no memory write occurs.
REQ-029 ACK state: x_ack = 1 for exactly that cycle, err as captured.
REQ-030 ACK state: requests are ignored; ACK -> IDLE on the next edge.
REQ-031 Latency: request sampled at edge N -> ack high in cycle N+2 -> earliest next grant at edge N+3; throughput one access per 3 cycles.
REQ-032 Requester must drop req by the edge ending its ack cycle; a req high in IDLE is always treated as a new request.
REQ-033 Outside SERVE states: m_addr = 0, m_wdata = 0, m_wenable = 0.
REQ-034 x_rdata holds its value until that port's next completion; d_rdata is not updated on writes.
REQ-035 Address compare uses the full 32 bits; no truncation or wrap-around of addresses.

Reset
REQ-036 On rst assertion, immediately and independent of clk: state = IDLE, last_grant = IF, if_ack = d_ack = err = 0.
REQ-037 On rst assertion, immediately: if_rdata = d_rdata = 0, command register = 0, m_wenable = 0.
REQ-038 Reset during SERVE_D: the in-flight write is suppressed, the pending transaction is discarded and no ack is issued.
REQ-039 First grant after rst deassertion: on the first clk edge with a request present.

Verification
REQ-040 Fetch only, if_addr = 5, mem[5] = 0xDEADBEEF: if_ack in cycle N+2, if_rdata = 0xDEADBEEF, err = 0, d_ack never asserts.
REQ-041 Data write d_addr = 7, d_wdata = 0x12345678, then a data read of addr 7: m_wenable high for exactly one cycle; read returns d_rdata = 0x12345678.
REQ-042 Both ports request continuously from reset: grant order D, IF, D, IF; ack pulses three cycles apart, never both acks in one cycle.
REQ-043 Data write d_addr = 128: d_ack and err pulse together, m_wenable stays 0, memory unchanged; if_addr = 200 gives if_rdata = 0 and err = 1.
REQ-044 rst asserted mid-cycle during SERVE_D of a write to addr 3: m_wenable drops at once, mem[3] unchanged, no d_ack; the first post-reset request is serviced normally.
